// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Fetch stage of the RV32I core. Owns the program counter (PCF), which
// addresses the combinational instruction memory, and captures the returned
// word into the IF/ID pipeline register together with its PC and PC+4.
// Decode can stall the stage and execute can redirect it (branch/jump).
// A retired-fetch counter records how many valid instructions were delivered.
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   defined   - a redirect to a target with bits [1:0] != 0 is not taken;
//               FetchFault is set (sticky until reset) and the stage halts.
//   undefined - redirect target bits [1:0] are silently cleared, FetchFault
//               is tied low and the HALT state is unreachable.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//   NOP_INSTR       instruction shown on InstrD while the slot is invalid
//
// Ports:
//   clk             system clock, all state updates on rising edge
//   reset           synchronous, active-high reset
//   Stall           hold PC and IF/ID register this cycle
//   Redirect        load RedirectTarget into PC and flush IF/ID
//   RedirectTarget  new fetch address from execute
//   PCF             current fetch address (instruction memory A)
//   InstrF          instruction word from memory (RD), combinational from PCF
//   InstrD          registered instruction to decode
//   PCD             registered PC of InstrD
//   PCPlus4D        registered PCD + 4
//   ValidD          InstrD holds a real fetched instruction
//   FetchCount      number of instructions delivered with ValidD = 1
//   FetchFault      misaligned redirect detected (optional feature only)
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount,
    output logic        FetchFault
);

    typedef enum logic [1:0] {
        WARM = 2'b00,   // first cycle after reset, no fetch captured yet
        RUN  = 2'b01,   // normal fetch
        HALT = 2'b10    // frozen after a misaligned redirect (optional feature)
    } state_t;

    state_t state;

    // Word-aligned redirect target: the low two bits are always dropped.
    logic [31:0] redirect_pc;
    assign redirect_pc = RedirectTarget & ~32'h0000_0003;

    // Sequential increment of the fetch address; wraps modulo 2^32 silently.
    logic [31:0] pc_plus4;
    assign pc_plus4 = PCF + 32'd4;

    // A redirect is honoured in WARM and RUN; HALT ignores everything.
    logic redirect_ok;
    assign redirect_ok = Redirect && (state != HALT);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (RedirectTarget[1:0] != 2'b00);

    logic fault_q;
    assign FetchFault = fault_q;
`else
    assign FetchFault = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Single state/datapath register block. Priority per cycle:
    //   reset > Redirect > Stall > advance
    // PCF is only ever assigned here, so it has no combinational path from
    // any input.
    // ------------------------------------------------------------------------
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others (PCD <= PCF, PCF <= PCF+4).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WARM;
            PCF        <= RESET_PC;
            InstrD     <= NOP_INSTR;
            PCD        <= 32'h0000_0000;
            PCPlus4D   <= 32'h0000_0000;
            ValidD     <= 1'b0;
            FetchCount <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            case (state)
                WARM, RUN: begin
                    if (redirect_ok) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            // Trap: keep PCF where it was, flush the slot
                            // and freeze the stage until reset.
                            fault_q <= 1'b1;
                            InstrD  <= NOP_INSTR;
                            ValidD  <= 1'b0;
                            state   <= HALT;
                        end else begin
                            PCF    <= redirect_pc;
                            InstrD <= NOP_INSTR;
                            ValidD <= 1'b0;
                            state  <= RUN;
                        end
`else
                        // Redirect beats Stall; PCD/PCPlus4D keep their
                        // values since the slot is marked invalid anyway.
                        PCF    <= redirect_pc;
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                        state  <= RUN;
`endif
                    end else if (Stall) begin
                        // Hold everything, including the WARM state.
                        state <= state;
                    end else if (state == WARM) begin
                        // Warm-up cycle: PCF held, nothing captured yet.
                        state <= RUN;
                    end else begin
                        InstrD     <= InstrF;
                        PCD        <= PCF;
                        PCPlus4D   <= pc_plus4;
                        ValidD     <= 1'b1;
                        PCF        <= pc_plus4;
                        FetchCount <= FetchCount + 32'd1;
                    end
                end

                HALT: begin
                    // Only reset leaves HALT; the slot stays invalid.
                    ValidD <= 1'b0;
                    InstrD <= NOP_INSTR;
                end

                default: begin
                    state <= WARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Directed testbench for instr_fetch_unit. Two instances share all inputs:
// dut_a uses RESET_PC = 0, dut_b uses RESET_PC = 32'hFFFF_FFFC for the
// wraparound case. A 16-word instruction memory answers combinationally.
// Expectations for the misaligned-redirect case follow FETCH_MISALIGN_TRAP_EN.
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;

    logic [31:0] pcf_a, instr_f_a, instr_d_a, pcd_a, pc4_a, count_a;
    logic        valid_a, fault_a;
    logic [31:0] pcf_b, instr_f_b, instr_d_b, pcd_b, pc4_b, count_b;
    logic        valid_b, fault_b;

    logic [31:0] mem [16];

    assign instr_f_a = mem[pcf_a[5:2]];
    assign instr_f_b = mem[pcf_b[5:2]];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .PCF(pcf_a), .InstrF(instr_f_a),
        .InstrD(instr_d_a), .PCD(pcd_a), .PCPlus4D(pc4_a), .ValidD(valid_a),
        .FetchCount(count_a), .FetchFault(fault_a)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .PCF(pcf_b), .InstrF(instr_f_b),
        .InstrD(instr_d_b), .PCD(pcd_b), .PCPlus4D(pc4_b), .ValidD(valid_b),
        .FetchCount(count_b), .FetchFault(fault_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two reset cycles, then release; returns just after the second edge.
    task automatic do_reset();
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // Values still reflect reset having been applied.
        n_vec++; if (pcf_a !== 32'h0) begin n_err++; $display("FAIL rst_pcf: got %h want %h", pcf_a, 32'h0); end
        n_vec++; if (instr_d_a !== 32'h13) begin n_err++; $display("FAIL rst_instr: got %h want %h", instr_d_a, 32'h13); end
        n_vec++; if (pcd_a !== 32'h0 || pc4_a !== 32'h0) begin n_err++; $display("FAIL rst_pcd: got %h/%h want 0/0", pcd_a, pc4_a); end
        n_vec++; if (valid_a !== 1'b0 || count_a !== 32'h0 || fault_a !== 1'b0) begin n_err++; $display("FAIL rst_flags: got v=%b cnt=%0d f=%b want 0 0 0", valid_a, count_a, fault_a); end
        // Cycle 1: warm-up.
        tick();
        n_vec++; if (valid_a !== 1'b0 || pcf_a !== 32'h0) begin n_err++; $display("FAIL warm: got v=%b pcf=%h want 0 00000000", valid_a, pcf_a); end
        // Cycle 2: word0 delivered.
        tick();
        n_vec++; if (instr_d_a !== 32'h0f300093 || pcd_a !== 32'h0 || pc4_a !== 32'h4 || valid_a !== 1'b1) begin
            n_err++; $display("FAIL first_fetch: got i=%h pcd=%h p4=%h v=%b want 0f300093 0 4 1", instr_d_a, pcd_a, pc4_a, valid_a); end
        // Cycle 3: word1 delivered.
        tick();
        n_vec++; if (instr_d_a !== 32'h00900113 || pcd_a !== 32'h4 || count_a !== 32'd2) begin
            n_err++; $display("FAIL second_fetch: got i=%h pcd=%h cnt=%0d want 00900113 4 2", instr_d_a, pcd_a, count_a); end
    endtask

    // Continues from test_reset: PCF = 0x08.
    task automatic test_stall();
        n_vec++; if (pcf_a !== 32'h8) begin n_err++; $display("FAIL stall_pre_pcf: got %h want %h", pcf_a, 32'h8); end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pcf_a !== 32'h8 || instr_d_a !== 32'h00900113 || valid_a !== 1'b1 || count_a !== 32'd2) begin
                n_err++; $display("FAIL stall_hold%0d: got pcf=%h i=%h v=%b cnt=%0d want 8 00900113 1 2", i, pcf_a, instr_d_a, valid_a, count_a); end
        end
        Stall = 1'b0;
        tick();
        n_vec++; if (instr_d_a !== mem[2] || pcd_a !== 32'h8 || count_a !== 32'd3) begin
            n_err++; $display("FAIL stall_release: got i=%h pcd=%h cnt=%0d want %h 8 3", instr_d_a, pcd_a, count_a, mem[2]); end
    endtask

    // Continues from test_stall: PCF = 0x0C, count = 3.
    task automatic test_redirect_stall();
        tick(2);
        n_vec++; if (pcf_a !== 32'h14 || count_a !== 32'd5) begin n_err++; $display("FAIL redir_pre: got pcf=%h cnt=%0d want 14 5", pcf_a, count_a); end
        Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h4;
        tick();
        Redirect = 1'b0; Stall = 1'b0;
        n_vec++; if (pcf_a !== 32'h4 || valid_a !== 1'b0 || instr_d_a !== 32'h13 || count_a !== 32'd5) begin
            n_err++; $display("FAIL redir_flush: got pcf=%h v=%b i=%h cnt=%0d want 4 0 00000013 5", pcf_a, valid_a, instr_d_a, count_a); end
        tick();
        n_vec++; if (instr_d_a !== 32'h00900113 || pcd_a !== 32'h4 || valid_a !== 1'b1 || count_a !== 32'd6) begin
            n_err++; $display("FAIL redir_refetch: got i=%h pcd=%h v=%b cnt=%0d want 00900113 4 1 6", instr_d_a, pcd_a, valid_a, count_a); end
    endtask

    // Redirect together with Stall during the warm-up cycle.
    task automatic test_warm_redirect();
        do_reset();
        Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h20;
        tick();
        Redirect = 1'b0; Stall = 1'b0;
        n_vec++; if (pcf_a !== 32'h20 || valid_a !== 1'b0) begin n_err++; $display("FAIL warm_redir: got pcf=%h v=%b want 20 0", pcf_a, valid_a); end
        tick();
        n_vec++; if (instr_d_a !== mem[8] || pcd_a !== 32'h20 || valid_a !== 1'b1) begin
            n_err++; $display("FAIL warm_redir_fetch: got i=%h pcd=%h v=%b want %h 20 1", instr_d_a, pcd_a, valid_a, mem[8]); end
    endtask

    task automatic test_wrap();
        do_reset();
        n_vec++; if (pcf_b !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_rst_pcf: got %h want fffffffc", pcf_b); end
        tick(2);
        n_vec++; if (pcd_b !== 32'hFFFF_FFFC || pc4_b !== 32'h0 || pcf_b !== 32'h0 || instr_d_b !== mem[15]) begin
            n_err++; $display("FAIL wrap: got pcd=%h p4=%h pcf=%h i=%h want fffffffc 0 0 %h", pcd_b, pc4_b, pcf_b, instr_d_b, mem[15]); end
    endtask

    task automatic test_misalign();
        do_reset();
        tick(3);  // warm-up + two fetches: PCF = 0x08, count = 2
        Redirect = 1'b1; RedirectTarget = 32'h0000_000E;
        tick();
        Redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_vec++; if (pcf_a !== 32'h8 || fault_a !== 1'b1 || valid_a !== 1'b0) begin
            n_err++; $display("FAIL misalign_trap: got pcf=%h f=%b v=%b want 8 1 0", pcf_a, fault_a, valid_a); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (valid_a !== 1'b0 || count_a !== 32'd2 || pcf_a !== 32'h8 || fault_a !== 1'b1) begin
                n_err++; $display("FAIL halt_hold%0d: got v=%b cnt=%0d pcf=%h f=%b want 0 2 8 1", i, valid_a, count_a, pcf_a, fault_a); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (fault_a !== 1'b0 || pcf_a !== 32'h0) begin n_err++; $display("FAIL halt_reset: got f=%b pcf=%h want 0 0", fault_a, pcf_a); end
`else
        n_vec++; if (pcf_a !== 32'hC || fault_a !== 1'b0 || valid_a !== 1'b0) begin
            n_err++; $display("FAIL misalign_clear: got pcf=%h f=%b v=%b want c 0 0", pcf_a, fault_a, valid_a); end
        tick();
        n_vec++; if (instr_d_a !== mem[3] || pcd_a !== 32'hC || count_a !== 32'd3) begin
            n_err++; $display("FAIL misalign_fetch: got i=%h pcd=%h cnt=%0d want %h c 3", instr_d_a, pcd_a, count_a, mem[3]); end
`endif
    endtask

    task automatic test_midstream_reset();
        do_reset();
        tick(6);  // warm-up + five fetches
        n_vec++; if (count_a !== 32'd5 || valid_a !== 1'b1) begin n_err++; $display("FAIL mid_pre: got cnt=%0d v=%b want 5 1", count_a, valid_a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (pcf_a !== 32'h0 || valid_a !== 1'b0 || count_a !== 32'h0 || instr_d_a !== 32'h13) begin
            n_err++; $display("FAIL mid_reset: got pcf=%h v=%b cnt=%0d i=%h want 0 0 0 00000013", pcf_a, valid_a, count_a, instr_d_a); end
    endtask

    initial begin
        mem[0] = 32'h0f300093;
        mem[1] = 32'h00900113;
        mem[2] = 32'h002081b3;
        mem[3] = 32'h40208233;
        mem[4] = 32'h00112023;
        for (int i = 5; i < 16; i++) mem[i] = 32'h0000_0093 | (32'(i) << 20);
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;

        test_reset();
        test_stall();
        test_redirect_stall();
        test_warm_redirect();
        test_wrap();
        test_misalign();
        test_midstream_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
